hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL use reset `reset` (asynchronous, active-high) and clock `clk`.
REQ-002 The block SHALL have these ports, clock and reset first:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous active-high reset.
- id_rs1, id_rs2  in  5 each  source register numbers of the ID-stage instruction.
- id_uses_rs1, id_uses_rs2  in  1 each  ID instruction reads that source.
- id_csr_access  in  1  ID instruction reads or writes a CSR.
- ex_rd  in  5  destination register of the EX-stage instruction (ID/EX output).
- ex_mem_read  in  1  EX instruction is a load.
- ex_csr_write  in  1  EX instruction writes a CSR.
- ex_redirect  in  1  branch taken or jump resolved in EX this cycle.
- ext_stall  in  1  memory not ready; freeze the whole pipeline.
- counter_clear  in  1  synchronous clear of both performance counters.
- pc_stall, if_id_stall, id_ex_stall, ex_mem_stall  out  1 each  hold the PC or the named pipeline register.
- if_id_flush, id_ex_flush  out  1 each  zero the named pipeline register (insert a bubble).
- state  out  1  0=RUN, 1=CSR_WAIT.
- stall_count, flush_count  out  32 each  saturating performance counters.

Function
REQ-003 Stall and flush outputs SHALL be combinational from the registered state and the current inputs; state, the wait counter and the performance counters SHALL be registered.
REQ-004 load_use SHALL be defined as: ex_mem_read && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)).
REQ-005 csr_hazard SHALL be defined as: ex_csr_write && id_csr_access.
REQ-006 Priority SHALL be ext_stall > ex_redirect > CSR_WAIT hold > csr_hazard > load_use.
REQ-007 When ext_stall=1, the block SHALL:
- assert pc_stall, if_id_stall, id_ex_stall and ex_mem_stall;
- hold both flushes at 0;
- hold state, the wait counter and both performance counters.
REQ-008 When ext_stall=0 and ex_redirect=1, the block SHALL:
- assert if_id_flush and id_ex_flush;
- hold all stalls at 0;
- go to RUN with the wait counter cleared, from either state.
REQ-009 When in RUN with load_use=1 (and no higher-priority event), the block SHALL assert pc_stall, if_id_stall and id_ex_flush for exactly that cycle and stay in RUN.
REQ-010 When in RUN with csr_hazard=1 (and no higher-priority event), the block SHALL:
- assert pc_stall, if_id_stall and id_ex_flush;
- load the 2-bit wait counter with 2;
- go to CSR_WAIT.
REQ-011 While in CSR_WAIT (no ext_stall or redirect), the block SHALL:
- assert pc_stall, if_id_stall and id_ex_flush;
- decrement the wait counter each cycle;
- return to RUN on the edge where the counter goes from 1 to 0.
REQ-012 Total ID hold for a CSR hazard SHALL be 3 cycles (T, T+1, T+2); the ID instruction SHALL advance at T+3.
REQ-013 In RUN with no hazard, all stall and flush outputs SHALL be 0.
REQ-014 id_ex_stall and ex_mem_stall SHALL be asserted only by ext_stall.
REQ-015 stall_count SHALL increment by 1 on every cycle with ext_stall=0 and pc_stall=1.
REQ-016 flush_count SHALL increment by 1 on every cycle with ext_stall=0 and ex_redirect=1.
REQ-017 Both counters SHALL saturate at 0xFFFFFFFF and never wrap.
REQ-018 counter_clear=1 SHALL zero both counters on the next edge, overriding increment and ext_stall hold; it SHALL have no effect on state.

Reset
REQ-019 Asserting reset SHALL immediately set state=RUN, wait counter=0, stall_count=0 and flush_count=0.
REQ-020 While reset=1, all stall and flush outputs SHALL be 0.
REQ-021 Reset asserted mid-CSR_WAIT SHALL abandon the wait; the first cycle after deassertion SHALL be RUN.

Verification
REQ-022 Load-use: ex_mem_read=1, ex_rd=5, id_uses_rs1=1, id_rs1=5 for one cycle -> pc_stall=if_id_stall=id_ex_flush=1 that cycle only; stall_count 0->1.
REQ-023 x0 load: same as REQ-022 but ex_rd=0 -> no stall or flush; stall_count unchanged.
REQ-024 CSR: ex_csr_write=1, id_csr_access=1 at T -> stalls asserted T..T+2, state=1 at T+1 and T+2, state=0 and no stall at T+3; stall_count=3.
REQ-025 Redirect plus load_use in the same cycle -> if_id_flush=id_ex_flush=1, pc_stall=0; flush_count 0->1, stall_count unchanged.
REQ-026 ext_stall=1 during CSR_WAIT at T+1 for 4 cycles -> all four stalls=1, flushes=0, counters frozen; after release, CSR_WAIT continues and stall_count ends at 3.
REQ-027 Saturation and clear: preload stall_count=0xFFFFFFFF, apply load_use -> stays 0xFFFFFFFF; then counter_clear=1 -> 0 next cycle.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use and CSR interlocks, branch/jump
// redirect flushes, external memory freeze, and saturating stall/flush counters.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// RUN      | normal issue; single-cycle load-use bubbles handled in place
// CSR_WAIT | ID held behind a CSR write in flight; r_wait_cnt cycles remain
module hazard_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic        id_csr_access,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_csr_write,
  input  logic        ex_redirect,
  input  logic        ext_stall,
  input  logic        counter_clear,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        id_ex_stall,
  output logic        ex_mem_stall,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic        state,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
);

  typedef enum logic {
    RUN      = 1'b0,
    CSR_WAIT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_wait_cnt;
  logic [1:0]  w_wait_nxt;
  logic [31:0] r_stall_count;
  logic [31:0] r_flush_count;
  logic        w_load_use;
  logic        w_csr_hazard;

  // Hazard detection from the ID and EX stage fields; x0 is never a real dependency.
  always_comb begin
    w_load_use   = ex_mem_read && (ex_rd != 5'd0) &&
                   ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                    (id_uses_rs2 && (id_rs2 == ex_rd)));
    w_csr_hazard = ex_csr_write && id_csr_access;
  end

  // Next-state and stall/flush decode, in priority order:
  // freeze > redirect > CSR wait > new CSR hazard > load-use.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    w_state_nxt  = r_state;
    w_wait_nxt   = r_wait_cnt;
    if (reset) begin
      // Outputs stay quiet while the registers are being reset.
      w_state_nxt = RUN;
      w_wait_nxt  = 2'd0;
    end else if (ext_stall) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
    end else if (ex_redirect) begin
      // The held ID instruction is on the wrong path, so any CSR wait is moot.
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      w_state_nxt = RUN;
      w_wait_nxt  = 2'd0;
    end else if (r_state == CSR_WAIT) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
      w_wait_nxt  = r_wait_cnt - 2'd1;
      // A zero count here is unreachable; fall back to RUN rather than wrap.
      if (r_wait_cnt <= 2'd1) begin
        w_state_nxt = RUN;
        w_wait_nxt  = 2'd0;
      end
    end else if (w_csr_hazard) begin
      // Cycle T of a three-cycle hold; the counter covers T+1 and T+2.
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
      w_state_nxt = CSR_WAIT;
      w_wait_nxt  = 2'd2;
    end else if (w_load_use) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  // State and CSR wait counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= RUN;
      r_wait_cnt <= 2'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
    end
  end

  // Saturating stall counter; clear wins over both increment and freeze.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_count <= 32'd0;
    end else if (counter_clear) begin
      r_stall_count <= 32'd0;
    end else if (!ext_stall && pc_stall && (r_stall_count != 32'hFFFF_FFFF)) begin
      r_stall_count <= r_stall_count + 32'd1;
    end
  end

  // Saturating redirect counter; clear wins over both increment and freeze.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flush_count <= 32'd0;
    end else if (counter_clear) begin
      r_flush_count <= 32'd0;
    end else if (!ext_stall && ex_redirect && (r_flush_count != 32'hFFFF_FFFF)) begin
      r_flush_count <= r_flush_count + 32'd1;
    end
  end

  // Drive registered values onto the output ports.
  always_comb begin
    state       = r_state;
    stall_count = r_stall_count;
    flush_count = r_flush_count;
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a driver applies one input vector per cycle
// and queues the hand-computed response; a monitor checks each queued entry.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic        id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, id_csr_access = 1'b0;
  logic        ex_mem_read = 1'b0, ex_csr_write = 1'b0, ex_redirect = 1'b0;
  logic        ext_stall = 1'b0, counter_clear = 1'b0;
  logic        pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic        if_id_flush, id_ex_flush, state;
  logic [31:0] stall_count, flush_count;

  hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_csr_access(id_csr_access), .ex_rd(ex_rd),
    .ex_mem_read(ex_mem_read), .ex_csr_write(ex_csr_write),
    .ex_redirect(ex_redirect), .ext_stall(ext_stall),
    .counter_clear(counter_clear),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall),
    .id_ex_stall(id_ex_stall), .ex_mem_stall(ex_mem_stall),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .state(state), .stall_count(stall_count), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst, ext, redir, clr, mr;
    logic [4:0] rd, rs1, rs2;
    logic       u1, u2, ca, cw;
  } in_t;

  // ctl = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush}
  typedef struct packed {
    logic [5:0]  ctl;
    logic        st;
    logic [31:0] sc, fc;
  } exp_t;

  localparam logic [5:0] NONE = 6'b000000;
  localparam logic [5:0] HZ   = 6'b110001;
  localparam logic [5:0] EXT  = 6'b111100;
  localparam logic [5:0] RED  = 6'b000011;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   vec_no = 0;

  function automatic in_t mk(input logic rst, ext, redir, clr, mr,
                             input logic [4:0] rd, rs1, rs2,
                             input logic u1, u2, ca, cw);
    in_t v;
    v.rst = rst; v.ext = ext; v.redir = redir; v.clr = clr; v.mr = mr;
    v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.u1 = u1; v.u2 = u2; v.ca = ca; v.cw = cw;
    return v;
  endfunction

  function automatic exp_t ex(input logic [5:0] ctl, input logic st,
                              input logic [31:0] sc, fc);
    exp_t e;
    e.ctl = ctl; e.st = st; e.sc = sc; e.fc = fc;
    return e;
  endfunction

  task automatic step(input in_t v, input exp_t e);
    @(negedge clk);
    reset         = v.rst;
    ext_stall     = v.ext;
    ex_redirect   = v.redir;
    counter_clear = v.clr;
    ex_mem_read   = v.mr;
    ex_rd         = v.rd;
    id_rs1        = v.rs1;
    id_rs2        = v.rs2;
    id_uses_rs1   = v.u1;
    id_uses_rs2   = v.u2;
    id_csr_access = v.ca;
    ex_csr_write  = v.cw;
    q.push_back(e);
  endtask

  // Monitor: outputs are presented every cycle; compare mid-low-phase.
  initial begin
    exp_t e;
    logic [5:0] act;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        vec_no++;
        act = {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, if_id_flush, id_ex_flush};
        checks++;
        if (act !== e.ctl) begin
          failures++;
          $display("FAIL ctl vec=%0d got=%b want=%b", vec_no, act, e.ctl);
        end
        checks++;
        if (state !== e.st) begin
          failures++;
          $display("FAIL state vec=%0d got=%b want=%b", vec_no, state, e.st);
        end
        checks++;
        if (stall_count !== e.sc || flush_count !== e.fc) begin
          failures++;
          $display("FAIL counters vec=%0d got sc=%h fc=%h want sc=%h fc=%h",
                   vec_no, stall_count, flush_count, e.sc, e.fc);
        end
      end
    end
  end

  in_t IDLE, LU, CSR;

  initial begin
    IDLE = mk(0,0,0,0,0, 5'd0, 5'd0, 5'd0, 0,0,0,0);
    LU   = mk(0,0,0,0,1, 5'd5, 5'd5, 5'd0, 1,0,0,0);
    CSR  = mk(0,0,0,0,0, 5'd0, 5'd0, 5'd0, 0,0,1,1);

    // Reset holds outputs quiet even with a load-use pattern present.
    step(mk(1,0,0,0,1, 5'd5, 5'd5, 5'd0, 1,0,0,0), ex(NONE, 0, 0, 0));
    step(IDLE, ex(NONE, 0, 0, 0));

    // Load-use on rs1: one-cycle bubble.
    step(LU,   ex(HZ,   0, 0, 0));
    step(IDLE, ex(NONE, 0, 1, 0));
    // Load to x0: no dependency.
    step(mk(0,0,0,0,1, 5'd0, 5'd0, 5'd0, 1,0,0,0), ex(NONE, 0, 1, 0));
    step(IDLE, ex(NONE, 0, 1, 0));
    // Load-use on rs2 only.
    step(mk(0,0,0,0,1, 5'd7, 5'd3, 5'd7, 1,1,0,0), ex(HZ, 0, 1, 0));
    // Matching rs1 that the instruction does not read.
    step(mk(0,0,0,0,1, 5'd9, 5'd9, 5'd0, 0,0,0,0), ex(NONE, 0, 2, 0));

    // CSR hazard: hold T..T+2, release at T+3.
    step(CSR,  ex(HZ,   0, 2, 0));
    step(IDLE, ex(HZ,   1, 3, 0));
    step(IDLE, ex(HZ,   1, 4, 0));
    step(IDLE, ex(NONE, 0, 5, 0));

    // Redirect beats load-use.
    step(mk(0,0,1,0,1, 5'd5, 5'd5, 5'd0, 1,0,0,0), ex(RED, 0, 5, 0));
    step(IDLE, ex(NONE, 0, 5, 1));

    // Freeze for 4 cycles in the middle of a CSR wait.
    step(CSR, ex(HZ, 0, 5, 1));
    for (int i = 0; i < 4; i++)
      step(mk(0,1,0,0,0, 5'd0, 5'd0, 5'd0, 0,0,0,0), ex(EXT, 1, 6, 1));
    step(IDLE, ex(HZ,   1, 6, 1));
    step(IDLE, ex(HZ,   1, 7, 1));
    step(IDLE, ex(NONE, 0, 8, 1));

    // Redirect abandons a CSR wait.
    step(CSR, ex(HZ, 0, 8, 1));
    step(mk(0,0,1,0,0, 5'd0, 5'd0, 5'd0, 0,0,0,0), ex(RED, 1, 9, 1));
    step(IDLE, ex(NONE, 0, 9, 2));

    // Freeze outranks redirect and does not count it.
    step(mk(0,1,1,0,0, 5'd0, 5'd0, 5'd0, 0,0,0,0), ex(EXT, 0, 9, 2));
    step(IDLE, ex(NONE, 0, 9, 2));
    // Clear overrides the freeze hold.
    step(mk(0,1,0,1,0, 5'd0, 5'd0, 5'd0, 0,0,0,0), ex(EXT, 0, 9, 2));
    step(IDLE, ex(NONE, 0, 0, 0));

    // Reset mid-wait takes effect immediately and leaves RUN afterwards.
    step(CSR,  ex(HZ, 0, 0, 0));
    step(IDLE, ex(HZ, 1, 1, 0));
    step(mk(1,0,0,0,0, 5'd0, 5'd0, 5'd0, 0,0,0,0), ex(NONE, 0, 0, 0));
    step(IDLE, ex(NONE, 0, 0, 0));
    step(IDLE, ex(NONE, 0, 0, 0));

    // Saturation: preload the stall counter, then clear it.
    @(posedge clk);
    #1 force dut.r_stall_count = 32'hFFFF_FFFF;
    #1 release dut.r_stall_count;
    step(LU,   ex(HZ,   0, 32'hFFFF_FFFF, 0));
    step(IDLE, ex(NONE, 0, 32'hFFFF_FFFF, 0));
    step(mk(0,0,0,1,0, 5'd0, 5'd0, 5'd0, 0,0,0,0), ex(NONE, 0, 32'hFFFF_FFFF, 0));
    step(IDLE, ex(NONE, 0, 0, 0));

    // Drain the queue within a bounded number of cycles.
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending want=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
